apb_addr_filter_regs: RTL and testbench

- APB3 slave holding NUM_RANGES programmable address windows (base/limit pairs), a global enable and a per-window enable mask.
- Adds a programmable wait-state count, PSLVERR on bad accesses, and a one-cycle-latency address-check port driven by the filter datapath.
- Sits between the APB master environment and the address-filter core.
- Next generation of the APB slave port: parametrised in range count, widths and wait states.

---
 rtl/apb_addr_filter_regs.sv | 214 +++++++++++++++++++++
 tb/tb_apb_addr_filter_regs.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_addr_filter_regs.sv
// APB3 register slave for an address-window filter with a registered address-check port.
// Optional per-window hit counters are built when APB_FILTER_HITCNT_EN is defined.

module apb_addr_filter_win #(
    parameter int FADDR_WIDTH = 32
) (
    input  logic                   en_i,
    input  logic [FADDR_WIDTH-1:0] base_i,
    input  logic [FADDR_WIDTH-1:0] limit_i,
    input  logic [FADDR_WIDTH-1:0] addr_i,
    output logic                   match_o
);
    // BASE > LIMIT makes both bounds unsatisfiable together, so no extra guard is needed.
    assign match_o = en_i && (addr_i >= base_i) && (addr_i <= limit_i);
endmodule

module apb_addr_filter_regs #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int FADDR_WIDTH = 32,
    parameter int NUM_RANGES  = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   pclock,
    input  logic                   presetn,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]  pwdata,
    output logic [DATA_WIDTH-1:0]  prdata,
    output logic                   pready,
    output logic                   pslverr,
    input  logic                   chk_valid,
    input  logic [FADDR_WIDTH-1:0] chk_addr,
    output logic                   chk_done,
    output logic                   chk_hit,
    output logic [2:0]             chk_idx
);
    localparam int IW = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1;
    localparam logic [31:0] WIN_END = 32'(16 + 8 * NUM_RANGES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                                 state_q;
    logic [3:0]                             wait_q;
    logic                                   pready_q, pslverr_q;
    logic [DATA_WIDTH-1:0]                  prdata_q;
    logic                                   ctrl_q;
    logic [NUM_RANGES-1:0]                  en_q;
    logic [NUM_RANGES-1:0][FADDR_WIDTH-1:0] base_q, limit_q;
    logic [2:0]                             last_idx_q;
    logic [15:0]                            miss_q;
    logic                                   chk_done_q, chk_hit_q;
    logic [2:0]                             chk_idx_q;

    logic [31:0]           addr_w;
    logic [IW-1:0]         win_sel;
    logic                  sel_ctrl, sel_en, sel_stat, sel_win, sel_cnt, map_ok;
    logic [DATA_WIDTH-1:0] rd_data, resp_data;
    logic                  wr_commit;
    logic [NUM_RANGES-1:0] match;
    logic                  any_hit;
    logic [2:0]            hit_idx;

`ifdef APB_FILTER_HITCNT_EN
    localparam logic [31:0] CNT_END = 32'(64 + 4 * NUM_RANGES);
    logic [NUM_RANGES-1:0][15:0] hcnt_q;
    logic [IW-1:0]               cnt_sel;
    assign cnt_sel = IW'((addr_w - 32'h40) >> 2);
`endif

    assign addr_w  = 32'(paddr);
    assign win_sel = IW'((addr_w - 32'h10) >> 3);

    always_comb begin
        sel_ctrl = (addr_w == 32'h0);
        sel_en   = (addr_w == 32'h4);
        sel_stat = (addr_w == 32'h8);
        sel_win  = (addr_w >= 32'h10) && (addr_w < WIN_END);
        sel_cnt  = 1'b0;
`ifdef APB_FILTER_HITCNT_EN
        sel_cnt  = !sel_win && (addr_w >= 32'h40) && (addr_w < CNT_END);
`endif
        map_ok   = (addr_w[1:0] == 2'b00) && (sel_ctrl || sel_en || sel_stat || sel_win || sel_cnt);
    end

    always_comb begin
        rd_data = '0;
        if (sel_ctrl) rd_data[0] = ctrl_q;
        else if (sel_en) rd_data[NUM_RANGES-1:0] = en_q;
        else if (sel_stat) begin
            rd_data[2:0]   = last_idx_q;
            rd_data[31:16] = miss_q;
        end
        else if (sel_win) rd_data[FADDR_WIDTH-1:0] = addr_w[2] ? limit_q[win_sel] : base_q[win_sel];
`ifdef APB_FILTER_HITCNT_EN
        else if (sel_cnt) rd_data[15:0] = hcnt_q[cnt_sel];
`endif
    end

    assign resp_data = (pwrite || !map_ok) ? '0 : rd_data;
    assign wr_commit = (state_q == ACCESS) && pready_q && psel && pwrite && !pslverr_q;

    // Response is registered one cycle ahead so pready/pslverr/prdata leave the FSM as flops.
    always_ff @(posedge pclock or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            case (state_q)
                IDLE: if (psel && !penable) state_q <= SETUP;
                SETUP: begin
                    if (!psel) state_q <= IDLE;
                    else begin
                        state_q <= ACCESS;
                        wait_q  <= '0;
                        if (WAIT_CYCLES == 0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= !map_ok;
                            prdata_q  <= resp_data;
                        end
                    end
                end
                ACCESS: begin
                    if (pready_q || !psel) state_q <= (psel && !penable) ? SETUP : IDLE;
                    else begin
                        wait_q <= wait_q + 4'd1;
                        if (wait_q + 4'd1 == 4'(WAIT_CYCLES)) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= !map_ok;
                            prdata_q  <= resp_data;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_RANGES; i++) begin : g_win
        apb_addr_filter_win #(.FADDR_WIDTH(FADDR_WIDTH)) u_win (
            .en_i    (ctrl_q & en_q[i]),
            .base_i  (base_q[i]),
            .limit_i (limit_q[i]),
            .addr_i  (chk_addr),
            .match_o (match[i])
        );
    end

    always_comb begin
        any_hit = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_RANGES - 1; i >= 0; i--) begin
            if (match[i]) begin
                any_hit = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge pclock or negedge presetn) begin
        if (!presetn) begin
            ctrl_q     <= 1'b0;
            en_q       <= '0;
            base_q     <= '0;
            limit_q    <= '0;
            last_idx_q <= '0;
            miss_q     <= '0;
            chk_done_q <= 1'b0;
            chk_hit_q  <= 1'b0;
            chk_idx_q  <= '0;
        end else begin
            chk_done_q <= chk_valid;
            chk_hit_q  <= chk_valid && any_hit;
            chk_idx_q  <= (chk_valid && any_hit) ? hit_idx : 3'd0;
            if (chk_valid && any_hit) last_idx_q <= hit_idx;
            if (wr_commit && sel_stat) miss_q <= '0;
            else if (chk_valid && !any_hit && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            if (wr_commit) begin
                if (sel_ctrl) ctrl_q <= pwdata[0];
                if (sel_en) en_q <= pwdata[NUM_RANGES-1:0];
                if (sel_win && addr_w[2]) limit_q[win_sel] <= pwdata[FADDR_WIDTH-1:0];
                if (sel_win && !addr_w[2]) base_q[win_sel] <= pwdata[FADDR_WIDTH-1:0];
            end
        end
    end

`ifdef APB_FILTER_HITCNT_EN
    always_ff @(posedge pclock or negedge presetn) begin
        if (!presetn) hcnt_q <= '0;
        else begin
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (wr_commit && sel_cnt && cnt_sel == IW'(i)) hcnt_q[i] <= '0;
                else if (chk_valid && any_hit && hit_idx == 3'(i) && hcnt_q[i] != 16'hFFFF)
                    hcnt_q[i] <= hcnt_q[i] + 16'd1;
            end
        end
    end
`endif

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign chk_done = chk_done_q;
    assign chk_hit  = chk_hit_q;
    assign chk_idx  = chk_idx_q;
endmodule

// File: tb/tb_apb_addr_filter_regs.sv
// Bench for apb_addr_filter_regs: directed steps plus random APB/check traffic against a register-level model.
`timescale 1ns/1ps
module tb_apb_addr_filter_regs;
    localparam int NR = 4;
`ifdef APB_FILTER_HITCNT_EN
    localparam bit HITCNT = 1'b1;
`else
    localparam bit HITCNT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        presetn;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        chk_valid, chk_done, chk_hit;
    logic [31:0] chk_addr;
    logic [2:0]  chk_idx;
    logic        psel3, penable3, pwrite3, pready3, pslverr3, chk_done3, chk_hit3;
    logic [7:0]  paddr3;
    logic [31:0] pwdata3, prdata3;
    logic [2:0]  chk_idx3;

    apb_addr_filter_regs #(.NUM_RANGES(NR), .WAIT_CYCLES(0)) dut (
        .pclock(clk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .chk_valid(chk_valid), .chk_addr(chk_addr), .chk_done(chk_done), .chk_hit(chk_hit),
        .chk_idx(chk_idx));

    apb_addr_filter_regs #(.NUM_RANGES(NR), .WAIT_CYCLES(3)) dut3 (
        .pclock(clk), .presetn(presetn), .psel(psel3), .penable(penable3), .pwrite(pwrite3),
        .paddr(paddr3), .pwdata(pwdata3), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
        .chk_valid(1'b0), .chk_addr(32'd0), .chk_done(chk_done3), .chk_hit(chk_hit3),
        .chk_idx(chk_idx3));

    int checks = 0;
    int errors = 0;

    // Reference model: the register file as plain variables.
    logic          m_ctrl;
    logic [NR-1:0] m_en;
    logic [31:0]   m_base [NR];
    logic [31:0]   m_limit[NR];
    logic [2:0]    m_last;
    int            m_miss;
    int            m_hc[NR];
    logic [31:0]   cq[$];

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ctrl = 1'b0; m_en = '0; m_last = 3'd0; m_miss = 0;
        for (int i = 0; i < NR; i++) begin
            m_base[i] = 32'd0; m_limit[i] = 32'd0; m_hc[i] = 0;
        end
    endtask

    function automatic bit mapped(input int x);
        if (x % 4 != 0) return 1'b0;
        if (x == 0 || x == 4 || x == 8) return 1'b1;
        if (x >= 16 && x < 16 + 8 * NR) return 1'b1;
        if (HITCNT && x >= 64 && x < 64 + 4 * NR) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input int x);
        if (x == 0) return {31'd0, m_ctrl};
        if (x == 4) return 32'(m_en);
        if (x == 8) return {m_miss[15:0], 13'd0, m_last};
        if (x >= 16 && x < 16 + 8 * NR) return (x % 8 == 0) ? m_base[(x - 16) / 8] : m_limit[(x - 16) / 8];
        if (x >= 64 && x < 64 + 4 * NR) return 32'(m_hc[(x - 64) / 4]);
        return 32'd0;
    endfunction

    task automatic m_write(input int x, input logic [31:0] d);
        if (x == 0) m_ctrl = d[0];
        else if (x == 4) m_en = d[NR-1:0];
        else if (x == 8) m_miss = 0;
        else if (x >= 16 && x < 16 + 8 * NR) begin
            if (x % 8 == 0) m_base[(x - 16) / 8] = d;
            else m_limit[(x - 16) / 8] = d;
        end
        else if (x >= 64 && x < 64 + 4 * NR) m_hc[(x - 64) / 4] = 0;
    endtask

    task automatic m_check(input logic [31:0] a, output logic hit, output logic [2:0] idx);
        hit = 1'b0; idx = 3'd0;
        for (int i = 0; i < NR; i++) begin
            if (m_ctrl && m_en[i] && a >= m_base[i] && a <= m_limit[i]) begin
                hit = 1'b1; idx = 3'(i); break;
            end
        end
        if (hit) begin
            m_last = idx;
            if (m_hc[idx] < 65535) m_hc[idx]++;
        end else if (m_miss < 65535) m_miss++;
    endtask

    // One APB transfer on the WAIT_CYCLES=0 slave; optionally fires a check in the commit cycle.
    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic sim, input logic [31:0] sa);
        int          waits;
        bit          e;
        logic [31:0] exp_rd;
        logic        sh;
        logic [2:0]  si;
        e = !mapped(int'(a));
        exp_rd = (wr || e) ? 32'd0 : m_read(int'(a));
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk); penable = 1'b1; waits = 0;
        cmp("prdata_before_ready", prdata, 32'd0);
        while (!pready && waits < 40) begin @(negedge clk); waits++; end
        cmp("wait_cycles", 32'(waits), 32'd1);
        cmp("pslverr", {31'd0, pslverr}, {31'd0, e});
        cmp("prdata", prdata, exp_rd);
        if (sim) begin chk_valid = 1'b1; chk_addr = sa; m_check(sa, sh, si); end
        if (wr && !e) m_write(int'(a), d);
        @(negedge clk); psel = 1'b0; penable = 1'b0;
        if (sim) begin
            chk_valid = 1'b0;
            cmp("sim_done", {31'd0, chk_done}, 32'd1);
            cmp("sim_hit", {31'd0, chk_hit}, {31'd0, sh});
            cmp("sim_idx", {29'd0, chk_idx}, {29'd0, si});
        end
    endtask

    task automatic apb3(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int waits);
        @(negedge clk); psel3 = 1'b1; penable3 = 1'b0; pwrite3 = wr; paddr3 = a; pwdata3 = d;
        @(negedge clk); penable3 = 1'b1; waits = 0;
        while (!pready3 && waits < 40) begin @(negedge clk); waits++; end
        rd = prdata3;
        cmp("dut3_pslverr", {31'd0, pslverr3}, 32'd0);
        @(negedge clk); psel3 = 1'b0; penable3 = 1'b0;
    endtask

    // Back-to-back checks of every queued address; each result is compared one cycle later.
    task automatic chk_run();
        logic       eh, ph;
        logic [2:0] ei, pi;
        bit         pend;
        pend = 1'b0; ph = 1'b0; pi = 3'd0;
        foreach (cq[i]) begin
            @(negedge clk);
            if (pend) begin
                cmp("chk_done", {31'd0, chk_done}, 32'd1);
                cmp("chk_hit", {31'd0, chk_hit}, {31'd0, ph});
                cmp("chk_idx", {29'd0, chk_idx}, {29'd0, pi});
            end
            chk_valid = 1'b1; chk_addr = cq[i];
            m_check(cq[i], eh, ei); ph = eh; pi = ei; pend = 1'b1;
        end
        @(negedge clk); chk_valid = 1'b0;
        if (pend) begin
            cmp("chk_done", {31'd0, chk_done}, 32'd1);
            cmp("chk_hit", {31'd0, chk_hit}, {31'd0, ph});
            cmp("chk_idx", {29'd0, chk_idx}, {29'd0, pi});
        end
        @(negedge clk);
        cmp("chk_done_low", {31'd0, chk_done}, 32'd0);
        cq.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          w, op, n;
        bit          saw;
        logic [7:0]  a;

        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        chk_valid = 1'b0; chk_addr = '0;
        psel3 = 1'b0; penable3 = 1'b0; pwrite3 = 1'b0; paddr3 = '0; pwdata3 = '0;
        m_reset();
        repeat (3) @(negedge clk);
        cmp("rst_prdata", prdata, 32'd0);
        cmp("rst_pready", {31'd0, pready}, 32'd0);
        cmp("rst_pslverr", {31'd0, pslverr}, 32'd0);
        cmp("rst_chk", {27'd0, chk_done, chk_hit, chk_idx}, 32'd0);
        presetn = 1'b1;

        apb(1'b0, 8'h00, 32'd0, 1'b0, 32'd0);
        apb(1'b0, 8'h04, 32'd0, 1'b0, 32'd0);
        apb(1'b0, 8'h10, 32'd0, 1'b0, 32'd0);

        apb3(1'b1, 8'h10, 32'h1000, rd, w);
        cmp("w3_write_waits", 32'(w), 32'd4);
        apb3(1'b0, 8'h10, 32'd0, rd, w);
        cmp("w3_read_waits", 32'(w), 32'd4);
        cmp("w3_read_data", rd, 32'h0000_1000);
        // psel drops before pready: the write must be abandoned.
        @(negedge clk); psel3 = 1'b1; penable3 = 1'b0; pwrite3 = 1'b1; paddr3 = 8'h10; pwdata3 = 32'hBAD;
        @(negedge clk); penable3 = 1'b1;
        repeat (2) @(negedge clk);
        psel3 = 1'b0; penable3 = 1'b0; saw = 1'b0;
        repeat (6) begin @(negedge clk); saw = saw | pready3; end
        cmp("w3_abort_no_pready", {31'd0, saw}, 32'd0);
        apb3(1'b0, 8'h10, 32'd0, rd, w);
        cmp("w3_abort_no_commit", rd, 32'h0000_1000);
        cmp("w3_chk_idle", {27'd0, chk_done3, chk_hit3, chk_idx3}, 32'd0);

        apb(1'b1, 8'h10, 32'h1000, 1'b0, 32'd0);
        apb(1'b1, 8'h14, 32'h1FFF, 1'b0, 32'd0);
        apb(1'b1, 8'h20, 32'h1800, 1'b0, 32'd0);
        apb(1'b1, 8'h24, 32'h2FFF, 1'b0, 32'd0);
        apb(1'b1, 8'h04, 32'h5, 1'b0, 32'd0);
        apb(1'b1, 8'h00, 32'h1, 1'b0, 32'd0);
        cq.push_back(32'h1800); cq.push_back(32'h2000); cq.push_back(32'h3000);
        chk_run();
        apb(1'b0, 8'h08, 32'd0, 1'b0, 32'd0);

        apb(1'b1, 8'h02, 32'hFFFF, 1'b0, 32'd0);
        apb(1'b1, 8'h30, 32'hFFFF, 1'b0, 32'd0);
        apb(1'b1, 8'h0C, 32'hFFFF, 1'b0, 32'd0);
        apb(1'b0, 8'h00, 32'd0, 1'b0, 32'd0);

        apb(1'b1, 8'h04, 32'h0, 1'b1, 32'h1800);
        cq.push_back(32'h1800);
        chk_run();

        apb(1'b1, 8'h04, 32'h1, 1'b0, 32'd0);
        apb(1'b1, 8'h40, 32'd0, 1'b0, 32'd0);
        repeat (3) cq.push_back(32'h1800);
        chk_run();
        apb(1'b0, 8'h40, 32'd0, 1'b0, 32'd0);
        apb(1'b1, 8'h40, 32'd0, 1'b0, 32'd0);
        apb(1'b0, 8'h40, 32'd0, 1'b0, 32'd0);

        for (int it = 0; it < 150; it++) begin
            op = int'($urandom_range(0, 3));
            a = 8'($urandom_range(0, 21) * 4);
            if ($urandom_range(0, 7) == 0) a = a | 8'($urandom_range(1, 3));
            case (op)
                0, 1: apb(1'b1, a, 32'($urandom_range(0, 32'h3FFF)), 1'b0, 32'd0);
                2: apb(1'b0, a, 32'd0, 1'b0, 32'd0);
                default: begin
                    n = int'($urandom_range(1, 4));
                    for (int k = 0; k < n; k++) cq.push_back(32'($urandom_range(0, 32'h4000)));
                    chk_run();
                end
            endcase
        end

        // Reset in the middle of a transfer.
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h1;
        @(negedge clk); penable = 1'b1;
        #1 presetn = 1'b0;
        #1 cmp("midrst_outputs", {27'd0, pready, pslverr, chk_done, chk_hit, chk_idx[0]}, 32'd0);
        cmp("midrst_prdata", prdata, 32'd0);
        @(negedge clk); psel = 1'b0; penable = 1'b0; presetn = 1'b1;
        m_reset();
        apb(1'b0, 8'h00, 32'd0, 1'b0, 32'd0);
        apb(1'b0, 8'h10, 32'd0, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
